pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding unit for the pipelined CPU; successor to the combinational forwarder.

---
 rtl/pipe_hazard_unit.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding unit: in-flight write scoreboard, operand forwarding, load-use stall, branch flush.
// Optional perf counters are compiled in when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_DEPTH  = 3,
    parameter int unsigned LOAD_STAGE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_ADDR_W-1:0]       id_rs,
    input  logic [REG_ADDR_W-1:0]       id_rt,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic                        id_wr_en,
    input  logic [REG_ADDR_W-1:0]       id_wr_dst,
    input  logic                        id_is_load,
    input  logic                        id_branch,
    input  logic                        br_taken,
    input  logic [DATA_W-1:0]           rf_a,
    input  logic [DATA_W-1:0]           rf_b,
    input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]           op_a,
    output logic [DATA_W-1:0]           op_b,
    output logic                        stall,
    output logic                        flush,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_flush_cnt
);

    logic [FWD_DEPTH-1:0]                 vld_q, vld_d;
    logic [FWD_DEPTH-1:0]                 wr_q, wr_d;
    logic [FWD_DEPTH-1:0]                 ld_q, ld_d;
    logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] dst_q, dst_d;
    logic                                 flush_q, flush_d;

    logic haz_a, haz_b;
    logic insert;

    // Scan oldest to youngest so the youngest matching entry overrides the rest.
    always_comb begin
        op_a  = rf_a;
        op_b  = rf_b;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
            if (id_use_rs && vld_q[k] && wr_q[k] && (dst_q[k] == id_rs) && (id_rs != '0)) begin
                op_a  = stage_data[k*DATA_W +: DATA_W];
                haz_a = ld_q[k] && (k < int'(LOAD_STAGE));
            end
            if (id_use_rt && vld_q[k] && wr_q[k] && (dst_q[k] == id_rt) && (id_rt != '0)) begin
                op_b  = stage_data[k*DATA_W +: DATA_W];
                haz_b = ld_q[k] && (k < int'(LOAD_STAGE));
            end
        end
    end

    // A slot shadowed by the previous cycle's flush is a bubble: no stall, no flush, no insert.
    always_comb begin
        stall   = id_valid && !flush_q && (haz_a || haz_b);
        flush   = id_valid && id_branch && br_taken && !stall && !flush_q;
        insert  = id_valid && !stall && !flush_q;
        flush_d = flush;
    end

    always_comb begin
        vld_d    = '0;
        wr_d     = '0;
        ld_d     = '0;
        dst_d    = '0;
        vld_d[0] = insert;
        wr_d[0]  = id_wr_en;
        ld_d[0]  = id_is_load;
        dst_d[0] = id_wr_dst;
        for (int k = 1; k < int'(FWD_DEPTH); k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q   <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
            dst_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            dst_q   <= dst_d;
            flush_q <= flush_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed table-driven bench for pipe_hazard_unit (default parameters).
// Each table row is one decode cycle; scoreboard state carries from row to row.
module tb_pipe_hazard_unit;

    localparam logic [31:0] RA = 32'hF000_000A;
    localparam logic [31:0] RB = 32'hF000_000B;
    localparam logic [31:0] D0 = 32'h0000_1234;
    localparam logic [31:0] D1 = 32'h0000_5555;
    localparam logic [31:0] D2 = 32'h0000_6666;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_rs;
        logic        use_rt;
        logic        wr;
        logic [4:0]  dst;
        logic        ld;
        logic        br;
        logic        tk;
        logic [31:0] sd0;
        logic [31:0] sd1;
        logic [31:0] sd2;
        logic [31:0] rfa;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_stall;
        logic        exp_flush;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_branch, br_taken;
    logic [4:0]  id_rs, id_rt, id_wr_dst;
    logic [31:0] rf_a, rf_b;
    logic [95:0] stage_data;
    logic [31:0] op_a, op_b, perf_stall_cnt, perf_flush_cnt;
    logic        stall, flush;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_wr_en      (id_wr_en),
        .id_wr_dst     (id_wr_dst),
        .id_is_load    (id_is_load),
        .id_branch     (id_branch),
        .br_taken      (br_taken),
        .rf_a          (rf_a),
        .rf_b          (rf_b),
        .stage_data    (stage_data),
        .op_a          (op_a),
        .op_b          (op_b),
        .stall         (stall),
        .flush         (flush),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [4:0] rs_i,
                                input logic [4:0] rt_i, input logic urs, input logic urt,
                                input logic w, input logic [4:0] d, input logic l,
                                input logic b, input logic t, input logic [31:0] s0,
                                input logic [31:0] s2, input logic [31:0] ra,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic es, input logic ef);
        vec_t x;
        x.rst = r;    x.vld = v;    x.rs = rs_i;  x.rt = rt_i;
        x.use_rs = urs; x.use_rt = urt; x.wr = w; x.dst = d; x.ld = l;
        x.br = b;     x.tk = t;     x.sd0 = s0;   x.sd1 = D1;  x.sd2 = s2;
        x.rfa = ra;   x.exp_a = ea; x.exp_b = eb;
        x.exp_stall = es; x.exp_flush = ef;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at posedge+1, compare at negedge, return at the next posedge+1.
    task automatic apply(input vec_t v, input string tag);
        rst        = v.rst;
        id_valid   = v.vld;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_use_rs  = v.use_rs;
        id_use_rt  = v.use_rt;
        id_wr_en   = v.wr;
        id_wr_dst  = v.dst;
        id_is_load = v.ld;
        id_branch  = v.br;
        br_taken   = v.tk;
        rf_a       = v.rfa;
        rf_b       = RB;
        stage_data = {v.sd2, v.sd1, v.sd0};
        @(negedge clk);
        chk({tag, ".op_a"}, op_a, v.exp_a);
        chk({tag, ".op_b"}, op_b, v.exp_b);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, v.exp_stall});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, v.exp_flush});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[25];

    initial begin
        //             rst v  rs  rt  urs urt wr dst ld br tk sd0        sd2        rfa  exp_a       exp_b   st fl
        vecs[0]  = mk(1, 1, 1,  2,  1, 1, 1, 3,  0, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[1]  = mk(1, 1, 3,  4,  1, 1, 0, 0,  0, 0, 0, D0,        D2,        RA, D0,         RB,     0, 0);
        vecs[2]  = mk(1, 1, 3,  0,  1, 0, 1, 5,  1, 0, 0, D0,        D2,        RA, D1,         RB,     0, 0);
        vecs[3]  = mk(1, 1, 6,  5,  1, 1, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         D0,     1, 0);
        vecs[4]  = mk(1, 1, 6,  5,  1, 1, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         D1,     0, 0);
        vecs[5]  = mk(1, 1, 9,  5,  0, 1, 1, 0,  0, 0, 0, D0,        D2,        RA, RA,         D2,     0, 0);
        vecs[6]  = mk(1, 1, 0,  5,  1, 1, 1, 7,  0, 0, 0, D0,        D2,        0,  0,          RB,     0, 0);
        vecs[7]  = mk(1, 1, 7,  9,  1, 0, 0, 0,  0, 0, 0, D0,        D2,        RA, D0,         RB,     0, 0);
        vecs[8]  = mk(1, 1, 7,  9,  1, 0, 1, 7,  0, 0, 0, D0,        D2,        RA, D1,         RB,     0, 0);
        vecs[9]  = mk(1, 1, 7,  7,  1, 1, 0, 0,  0, 0, 0, 32'hAAAA,  32'hBBBB,  RA, 32'hAAAA,   32'hAAAA, 0, 0);
        vecs[10] = mk(1, 1, 7,  9,  1, 0, 0, 0,  0, 1, 1, D0,        D2,        RA, D1,         RB,     0, 1);
        vecs[11] = mk(1, 1, 7,  9,  1, 0, 1, 8,  0, 1, 1, D0,        D2,        RA, D2,         RB,     0, 0);
        vecs[12] = mk(1, 1, 8,  9,  1, 0, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[13] = mk(1, 1, 9,  9,  0, 0, 1, 10, 1, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[14] = mk(1, 1, 10, 9,  1, 0, 0, 0,  0, 1, 1, D0,        D2,        RA, D0,         RB,     1, 0);
        vecs[15] = mk(1, 1, 10, 9,  1, 0, 0, 0,  0, 1, 1, D0,        D2,        RA, D1,         RB,     0, 1);
        vecs[16] = mk(1, 1, 10, 9,  1, 0, 0, 0,  0, 0, 0, D0,        D2,        RA, D2,         RB,     0, 0);
        vecs[17] = mk(1, 1, 9,  9,  0, 0, 1, 11, 0, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[18] = mk(1, 1, 9,  9,  0, 0, 1, 11, 1, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[19] = mk(1, 1, 9,  11, 0, 1, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         D0,     1, 0);
        vecs[20] = mk(1, 1, 9,  11, 0, 1, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         D1,     0, 0);
        vecs[21] = mk(1, 1, 9,  9,  0, 0, 1, 12, 1, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[22] = mk(1, 1, 12, 12, 0, 0, 0, 0,  0, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[23] = mk(1, 1, 9,  9,  0, 0, 1, 13, 1, 0, 0, D0,        D2,        RA, RA,         RB,     0, 0);
        vecs[24] = mk(1, 0, 13, 9,  1, 0, 0, 0,  0, 0, 0, D0,        D2,        RA, D0,         RB,     0, 0);

        rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_wr_en = 1'b0; id_wr_dst = '0; id_is_load = 1'b0;
        id_branch = 1'b0; br_taken = 1'b0; rf_a = RA; rf_b = RB; stage_data = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) apply(vecs[i], $sformatf("row%0d", i));

        @(negedge clk);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`else
        chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Mid-stream reset: three live writers and a pending load-use stall.
        apply(mk(1, 1, 9, 9, 0, 0, 1, 20, 0, 0, 0, D0, D2, RA, RA, RB, 0, 0), "rs_fill0");
        apply(mk(1, 1, 9, 9, 0, 0, 1, 21, 0, 0, 0, D0, D2, RA, RA, RB, 0, 0), "rs_fill1");
        apply(mk(1, 1, 9, 9, 0, 0, 1, 22, 1, 0, 0, D0, D2, RA, RA, RB, 0, 0), "rs_fill2");
        apply(mk(0, 1, 22, 21, 1, 1, 0, 0, 0, 0, 0, D0, D2, RA, D0, D1, 1, 0), "rs_assert");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        apply(mk(1, 1, 22, 21, 1, 1, 0, 0, 0, 0, 0, D0, D2, RA, RA, RB, 0, 0), "rs_after");
        apply(mk(1, 1, 20, 21, 1, 1, 0, 0, 0, 0, 0, D0, D2, RA, RA, RB, 0, 0), "rs_clean");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
